// File: rtl/demux4_buffer_if.sv
// demux4_buffer_if: handshake bundle for the 1-to-4 registered demultiplexer.
//   in_data/in_select/in_valid -> producer word, destination code and qualifier
//   in_ready                   <- block accepts the offered word this cycle
//   output0..output3           <- per-destination holding registers
//   out_valid[3:0]             <- bit i: output i holds an undelivered word
//   out_ready[3:0]             -> bit i: consumer i takes output i this cycle
//   busy                       <- any destination holds an undelivered word
// slave is the demultiplexer side; master is the producer/consumer side.
interface demux4_buffer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_select;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] output0;
  logic [DATA_W-1:0] output1;
  logic [DATA_W-1:0] output2;
  logic [DATA_W-1:0] output3;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic              busy;

  modport slave (
    input  in_data, in_select, in_valid, out_ready,
    output in_ready, output0, output1, output2, output3, out_valid, busy
  );

  modport master (
    output in_data, in_select, in_valid, out_ready,
    input  in_ready, output0, output1, output2, output3, out_valid, busy
  );
endinterface

// File: rtl/demux4_buffer.sv
// demux4_buffer: one-to-four registered demultiplexer with valid/ready on
// every port. One word per cycle is steered by in_select into one of four
// single-word holding registers; each register is released independently by
// its own consumer, so backpressure on one destination only stalls writes
// aimed at that destination.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; empties all ports, clears registers
//   bus  - demux4_buffer_if.slave (producer side in_*, consumer side out*)
module demux4_buffer #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  demux4_buffer_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_p0 [4];
  state_t            state_nx [4];
  logic [DATA_W-1:0] data_p0  [4];
  logic [3:0]        vld_p0;
  logic [3:0]        load;
  logic              accept;

  always_comb begin
    vld_p0 = '0;
    for (int i = 0; i < 4; i++) begin
      vld_p0[i] = (state_p0[i] == FULL);
    end
  end

  // A full port can still take a word if its consumer empties it this cycle.
  assign bus.in_ready = ~vld_p0[bus.in_select] | bus.out_ready[bus.in_select];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    load     = '0;
    state_nx = state_p0;
    for (int i = 0; i < 4; i++) begin
      load[i] = accept && (bus.in_select == 2'(i));
      // Load wins over drain: old word leaves, new word lands, port stays full.
      if (load[i]) begin
        state_nx[i] = FULL;
      end else if (vld_p0[i] && bus.out_ready[i]) begin
        state_nx[i] = EMPTY;
      end
    end
  end

  // Stage p0: per-port state and holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_p0[i] <= EMPTY;
        data_p0[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_p0[i] <= state_nx[i];
        if (load[i]) begin
          data_p0[i] <= bus.in_data;
        end
      end
    end
  end

  assign bus.output0   = data_p0[0];
  assign bus.output1   = data_p0[1];
  assign bus.output2   = data_p0[2];
  assign bus.output3   = data_p0[3];
  assign bus.out_valid = vld_p0;
  assign bus.busy      = |vld_p0;

endmodule

// File: doc/demux4_buffer.md
# demux4_buffer

One-to-four registered demultiplexer with valid/ready handshakes on every port, the steering counterpart of the 4-to-1 operand mux in the DLX multicycle datapath. It accepts one N-bit word per cycle from a single producer, such as the ALU result or memory data path, and delivers it to one of four destinations selected by a 2-bit code. Each destination holds one buffered word until its consumer takes it. Backpressure on one destination stalls only the writes aimed at that destination.

## Interface
- N, 32, data width in bits
- Clock  input  1  rising-edge clock; the only clock in the block
- Reset  input  1  reset, synchronous, active-high
- InData  input  N  word to steer
- InSelect  input  2  destination: 2'b00→Output0, 2'b01→Output1, 2'b10→Output2, 2'b11→Output3
- InValid  input  1  producer presents InData/InSelect
- InReady  output  1  block accepts the word this cycle
- Output0..Output3  output  N each  per-port holding registers
- OutValid  output  4  bit i set = Output i holds an undelivered word
- OutReady  input  4  bit i set = consumer i takes Output i this cycle
- Busy  output  1  OR of OutValid

## Operation
- Per port i, a 2-state FSM: EMPTY (OutValid[i]=0) and FULL (OutValid[i]=1).
- Accept condition: accept = InValid & InReady.
- InReady is combinational: InReady = ~OutValid[InSelect] | OutReady[InSelect]. It does not depend on InValid.
- Port i is loaded when accept is high and InSelect equals i. On load:
  - Output i ← InData.
  - Port i goes to, or stays in, FULL.
- Port i drains when OutValid[i] & OutReady[i] are both high and there is no load to port i in the same cycle. On drain, port i goes to EMPTY.
- Simultaneous drain and load on port i: the consumer takes the old word, the new word is registered, and the port stays FULL. No bubble and no loss.
- Output i is held unchanged while its port is FULL without a load. It also keeps its last value while EMPTY; consumers ignore it when OutValid[i]=0.
- Ports are independent. Any number of ports may drain in one cycle. At most one port loads per cycle.
- Offered words are never dropped or duplicated. While InValid=1 and InReady=0, the producer holds InData and InSelect stable.
- InSelect, InData and OutReady are don't-care when they are not qualified by their valid signal.

## Timing
- Reset (synchronous, evaluated on the rising Clock edge):
  - All FSMs go to EMPTY.
  - OutValid = 4'b0000; Output0..3 = 0; Busy = 0.
  - InReady reads 1 in the cycle after Reset deasserts.
- Reset mid-operation: buffered words are discarded. A word offered in the same cycle as Reset=1 is not accepted, so no port loads that cycle.
- Latency: a word accepted at edge k appears on Output i with OutValid[i]=1 after edge k. That is 1 cycle.
- Throughput: 1 word per cycle, including back-to-back words to the same port, as long as that port's OutReady is held high.
- A full port with OutReady low forces InReady=0 whenever InSelect points at it. Writes to other ports still proceed in that state.
- No combinational path runs from InData to any output. InSelect and OutReady reach InReady combinationally.

## Test plan
- Reset state:
  - Stimulus: hold Reset=1 for 2 cycles, then release with InValid=0.
  - Required response: OutValid=0000, Output0..3=0, Busy=0, InReady=1.
- Single transfer:
  - Stimulus: InData=32'hDEADBEEF, InSelect=2, InValid=1 for 1 cycle, OutReady=0000.
  - Required response: next cycle Output2=DEADBEEF, OutValid=0100, Busy=1. After OutReady[2]=1 for 1 cycle, OutValid=0000.
- Backpressure:
  - Stimulus: port 1 FULL with 32'h11, OutReady[1]=0, then offer 32'h22 to port 1.
  - Required response: InReady=0 and Output1 stays 11. When OutReady[1]=1, the same cycle reads InReady=1, and the next cycle shows Output1=22 with OutValid[1] still 1.
- Independence:
  - Stimulus: port 0 FULL and stalled, then offer 32'hA5 to port 3.
  - Required response: InReady=1, Output3=A5 next cycle, and Output0 unchanged.
- Streaming:
  - Stimulus: OutReady=1111, offer 8 consecutive words 1..8 with InSelect cycling 0,1,2,3.
  - Required response: InReady stays 1 throughout. Each port sees exactly its two words in order, each with a 1-cycle valid pulse.
- Reset mid-operation:
  - Stimulus: all ports FULL, then assert Reset=1 while a word to port 0 is offered.
  - Required response: next cycle OutValid=0000, Output0..3=0, and the offered word is not loaded.
